// File: rtl/ulight_pll_ctrl_pkg.sv
// Shared types and constants for the uLight PLL reset/lock sequencer.
package ulight_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_READY     = 3'd3,
    ST_FAIL      = 3'd4
  } pll_ctrl_state_t;

  localparam int LOST_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ulight_sync_2ff.sv
// Two-flop synchroniser for slow level signals crossing into the local clock.
// Latency 2 edges; no flow control.
module ulight_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ulight_fifo_pll_ctrl.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies a synchronised locked over a
// stability window, retries on timeout and raises a sticky fail when retries run out.
module ulight_fifo_pll_ctrl
  import ulight_pll_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES       = 16,
  parameter int LOCK_TIMEOUT       = 100000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  pll_ready,
  output logic                  pll_fail,
  output logic [LOST_CNT_W-1:0] lock_lost_cnt,
  output logic [2:0]            state
);

  localparam int CNT_W   = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES)) + 1;
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  pll_ctrl_state_t       state_q, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [RETRY_W-1:0]    retry_cnt, retry_d;
  logic [LOST_CNT_W-1:0] lost_d;
  logic                  lost_inc;
  logic                  armed;
  logic                  locked_s;
  logic                  pll_rst_d, pll_ready_d, pll_fail_d;

  ulight_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RESET;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_lost_cnt <= '0;
      armed         <= 1'b0;
      pll_rst       <= 1'b1;
      pll_ready     <= 1'b0;
      pll_fail      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt           <= cnt_d;
      retry_cnt     <= retry_d;
      lock_lost_cnt <= lost_d;
      armed         <= 1'b1;
      pll_rst       <= pll_rst_d;
      pll_ready     <= pll_ready_d;
      pll_fail      <= pll_fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt + CNT_W'(1);
    retry_d  = retry_cnt;
    lost_inc = 1'b0;
    if (relock_req) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          // The first edge after rst_n release only arms the sequencer, so the
          // initial pulse spans RESET_CYCLES full edges after release.
          if (!armed) begin
            cnt_d = cnt;
          end else if (cnt == RESET_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_cnt == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_RESET;
              retry_d = retry_cnt + RETRY_W'(1);
            end
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        ST_READY: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d  = ST_RESET;
            lost_inc = 1'b1;
          end
        end
        ST_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the edge that enters it.
  always_comb begin
    pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
    pll_ready_d = (state_d == ST_READY);
    pll_fail_d  = (state_d == ST_FAIL);
    lost_d      = lock_lost_cnt;
    if (lost_inc && (lock_lost_cnt != {LOST_CNT_W{1'b1}})) begin
      lost_d = lock_lost_cnt + LOST_CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ulight_fifo_pll_ctrl.sv
// Directed self-checking bench for ulight_fifo_pll_ctrl with small parameters.
module tb_ulight_fifo_pll_ctrl;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       pll_ready;
  logic       pll_fail;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state;

  int checks;
  int failures;

  ulight_fifo_pll_ctrl #(
    .RESET_CYCLES       (4),
    .LOCK_TIMEOUT       (20),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRIES        (2)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .pll_ready     (pll_ready),
    .pll_fail      (pll_fail),
    .lock_lost_cnt (lock_lost_cnt),
    .state         (state)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input logic level, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pll_ready === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    tick();
    tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%0d exp=1", pll_rst); end
    checks++; if (pll_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0d exp=0", pll_ready); end
    checks++; if (pll_fail !== 1'b0) begin failures++; $display("FAIL reset_fail got=%0d exp=0", pll_fail); end
    checks++; if (lock_lost_cnt !== 8'd0) begin failures++; $display("FAIL reset_lost got=%0d exp=0", lock_lost_cnt); end
  endtask

  task automatic test_clean_lock();
    logic early;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL clean_rst_hold edge=%0d got=%0d exp=1", i, pll_rst); end
    end
    tick();
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL clean_rst_fall got=%0d exp=0", pll_rst); end
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL clean_wait_state got=%0d exp=1", state); end
    repeat (5) tick();
    pll_locked = 1'b1;
    early = 1'b0;
    // Edge k=0 is the first edge to see the new lock level; ready is due at k=2+8.
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k < 10 && pll_ready === 1'b1) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL clean_ready_early got=%0d exp=0", early); end
    checks++; if (pll_ready !== 1'b1) begin failures++; $display("FAIL clean_ready got=%0d exp=1", pll_ready); end
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL clean_state got=%0d exp=3", state); end
    checks++; if (pll_fail !== 1'b0) begin failures++; $display("FAIL clean_fail got=%0d exp=0", pll_fail); end
  endtask

  task automatic test_priority();
    logic ok;
    pll_locked = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL prio_state got=%0d exp=0", state); end
    checks++; if (lock_lost_cnt !== 8'd0) begin failures++; $display("FAIL prio_lost got=%0d exp=0", lock_lost_cnt); end
    checks++; if (pll_ready !== 1'b0) begin failures++; $display("FAIL prio_ready got=%0d exp=0", pll_ready); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL prio_pll_rst got=%0d exp=1", pll_rst); end
    pll_locked = 1'b1;
    wait_ready(1'b1, 60, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL prio_relock got=%0d exp=1", ok); end
  endtask

  task automatic test_glitchy_lock();
    logic early;
    do_reset();
    repeat (5) tick();
    early = 1'b0;
    // Lock high before edges 0..4, low before edge 5, high from edge 6 on.
    for (int k = 0; k <= 16; k++) begin
      pll_locked = (k != 5);
      tick();
      if (k == 7) begin
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL glitch_back_to_wait got=%0d exp=1", state); end
      end
      if (k < 16 && pll_ready === 1'b1) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL glitch_ready_early got=%0d exp=0", early); end
    checks++; if (pll_ready !== 1'b1) begin failures++; $display("FAIL glitch_ready got=%0d exp=1", pll_ready); end
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL glitch_state got=%0d exp=3", state); end
  endtask

  task automatic test_lock_loss();
    logic ok;
    int   timeouts;
    pll_locked = 1'b0;
    tick();
    tick();
    checks++; if (pll_ready !== 1'b1) begin failures++; $display("FAIL loss_ready_hold got=%0d exp=1", pll_ready); end
    tick();
    checks++; if (pll_ready !== 1'b0) begin failures++; $display("FAIL loss_ready_drop got=%0d exp=0", pll_ready); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL loss_pll_rst got=%0d exp=1", pll_rst); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL loss_state got=%0d exp=0", state); end
    checks++; if (lock_lost_cnt !== 8'd1) begin failures++; $display("FAIL loss_cnt_first got=%0d exp=1", lock_lost_cnt); end
    pll_locked = 1'b1;
    wait_ready(1'b1, 60, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL loss_relock got=%0d exp=1", ok); end
    timeouts = 0;
    for (int n = 2; n <= 260; n++) begin
      pll_locked = 1'b0;
      wait_ready(1'b0, 10, ok);
      if (!ok) timeouts++;
      pll_locked = 1'b1;
      wait_ready(1'b1, 60, ok);
      if (!ok) timeouts++;
    end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL loss_loop_timeouts got=%0d exp=0", timeouts); end
    checks++; if (lock_lost_cnt !== 8'd255) begin failures++; $display("FAIL loss_cnt_sat got=%0d exp=255", lock_lost_cnt); end
  endtask

  task automatic test_async_reset_mid_stable();
    logic ok;
    pll_locked = 1'b0;
    wait_ready(1'b0, 10, ok);
    pll_locked = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (state === 3'd2) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    tick();
    checks++; if (state !== 3'd2 || ok !== 1'b1) begin failures++; $display("FAIL async_pre_stable got=%0d exp=2", state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL async_state got=%0d exp=0", state); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL async_pll_rst got=%0d exp=1", pll_rst); end
    checks++; if (pll_ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%0d exp=0", pll_ready); end
    checks++; if (pll_fail !== 1'b0) begin failures++; $display("FAIL async_fail got=%0d exp=0", pll_fail); end
    checks++; if (lock_lost_cnt !== 8'd0) begin failures++; $display("FAIL async_lost got=%0d exp=0", lock_lost_cnt); end
  endtask

  task automatic test_timeout_fail();
    int fail_at, run, pulses, bad_len;
    do_reset();
    fail_at = 0;
    run     = 0;
    pulses  = 0;
    bad_len = 0;
    // Three attempts of 4 reset + 20 wait edges; FAIL is entered on edge 73.
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (pll_fail === 1'b1) begin
        fail_at = n;
        break;
      end
      if (pll_rst === 1'b1) begin
        run++;
      end else if (run > 0) begin
        pulses++;
        if (run != 4) bad_len++;
        run = 0;
      end
    end
    checks++; if (fail_at !== 73) begin failures++; $display("FAIL tmo_fail_edge got=%0d exp=73", fail_at); end
    checks++; if (pulses !== 3) begin failures++; $display("FAIL tmo_pulses got=%0d exp=3", pulses); end
    checks++; if (bad_len !== 0) begin failures++; $display("FAIL tmo_pulse_len got=%0d exp=0", bad_len); end
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL tmo_state got=%0d exp=4", state); end
    tick();
    tick();
    checks++; if (pll_fail !== 1'b1) begin failures++; $display("FAIL tmo_fail_sticky got=%0d exp=1", pll_fail); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL tmo_rst_held got=%0d exp=1", pll_rst); end
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checks++; if (pll_fail !== 1'b0) begin failures++; $display("FAIL relock_fail_clr got=%0d exp=0", pll_fail); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL relock_state got=%0d exp=0", state); end
    repeat (3) tick();
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL relock_rst_hold got=%0d exp=1", pll_rst); end
    tick();
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL relock_rst_fall got=%0d exp=0", pll_rst); end
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL relock_wait got=%0d exp=1", state); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    test_reset();
    test_clean_lock();
    test_priority();
    test_glitchy_lock();
    test_lock_loss();
    test_async_reset_mid_stable();
    test_timeout_fail();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ulight_fifo_pll_ctrl.md
# ulight_fifo_pll_ctrl

Reset and lock sequencer for the uLight FIFO 400 MHz PLL. It runs on the free-running 100 MHz reference clock. It drives the PLL reset, qualifies the asynchronous `locked` output through a synchroniser and a stability window, and retries on lock timeout. Downstream logic is released only through a clean `pll_ready`. It sits between the board clock/reset and the PLL wrapper and feeds the reset tree of the 400 MHz SpaceWire/FIFO domain.

## Interface
- `RESET_CYCLES`, 16: number of cycles `pll_rst` is held high on each reset attempt (≥1).
- `LOCK_TIMEOUT`, 100000: WAIT_LOCK cycles allowed before a retry (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-locked cycles required before ready (≥1).
- `MAX_RETRIES`, 3: retries allowed after the first attempt before FAIL.
- `refclk`  in  1  100 MHz reference clock; the block's only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL `locked`; asynchronous to `refclk`.
- `relock_req`  in  1  single-cycle request to restart the whole sequence.
- `pll_rst`  out  1  active-high reset to the PLL.
- `pll_ready`  out  1  PLL output is stable and usable.
- `pll_fail`  out  1  retries exhausted; sticky until `relock_req` or `rst_n`.
- `lock_lost_cnt`  out  8  saturating count of lock losses while in READY.
- `state`  out  3  current FSM state, for debug/CSR.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `locked_s`; `locked_s` is the only form of lock the FSM uses.
- **RESET:** `pll_rst`=1 for exactly `RESET_CYCLES` cycles, then go to WAIT_LOCK with the counter cleared.
- **WAIT_LOCK:** `pll_rst`=0.
  - `locked_s`=1 → STABLE, counter cleared.
  - Counter reaches `LOCK_TIMEOUT`-1 without lock:
    - if `retry_cnt`==`MAX_RETRIES` → FAIL;
    - otherwise `retry_cnt`++ and → RESET.
- **STABLE:** counts consecutive cycles with `locked_s`=1.
  - `locked_s`=0 → WAIT_LOCK, counter cleared, `retry_cnt` unchanged.
  - After `LOCK_STABLE_CYCLES` cycles → READY, `retry_cnt` cleared.
- **READY:** `pll_ready`=1. `locked_s`=0 → RESET, and `lock_lost_cnt`++ (saturates at 255).
- **FAIL:** `pll_rst`=1 and `pll_fail`=1. Only `relock_req` or `rst_n` leaves this state.
- **`relock_req`:**
  - In any state → RESET, with `retry_cnt` and `pll_fail` cleared.
  - It has priority over every other transition in the same cycle; a simultaneous lock loss in READY does not increment `lock_lost_cnt`.
  - In RESET it restarts the hold count.
- State encoding: RESET=0, WAIT_LOCK=1, STABLE=2, READY=3, FAIL=4.
- Counter width: `$clog2` of the largest of the three cycle parameters, plus 1. Comparisons are unsigned.

## Timing
- **Reset values** while `rst_n`=0: state=RESET, `pll_rst`=1, `pll_ready`=0, `pll_fail`=0, `lock_lost_cnt`=0, `retry_cnt`=0, counter=0, synchroniser flops=0.
- **Output registers:** all outputs are registered and glitch-free. `pll_ready`, `pll_rst` and `pll_fail` change on the same edge that enters the corresponding state.
- **First attempt after `rst_n` release:** `pll_rst` falls `RESET_CYCLES` edges after the first rising edge following release.
- **Lock qualification:** if `pll_locked` rises before edge t (and stays high), `locked_s` is high after edge t+1 and STABLE is entered at edge t+2. `pll_ready` rises at edge t+2+`LOCK_STABLE_CYCLES`.
- **Lock loss:** `pll_locked` falling reaches `pll_ready`=0 and `pll_rst`=1 within 3 edges.
- **Total attempts before FAIL:** `MAX_RETRIES`+1.

## Structure
- Package `ulight_pll_ctrl_pkg` holds:
  - the `pll_ctrl_state_t` enum (3-bit, encodings as above);
  - a `LOST_CNT_W`=8 constant.
- Sub-module `ulight_sync_2ff` (parameterised width) provides the `pll_locked` synchroniser. It has the same clock and async active-low reset and is reusable elsewhere in the design.
- Single FSM process plus one shared cycle counter, one retry counter and one loss counter.

## Test plan
All scenarios use parameters `RESET_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- **Clean lock:** release `rst_n`; `pll_rst` high for 4 cycles; assert `pll_locked` 5 cycles later → `pll_ready`=1 exactly 10 edges after `pll_locked` rises, `state`=3, `pll_fail`=0.
- **Glitchy lock:** `pll_locked` high for 5 cycles, low for 1, then high → no `pll_ready` during the glitch; the stability count restarts; ready is reached 10 edges after the final rise.
- **Timeout/fail:** hold `pll_locked`=0 → exactly 3 `pll_rst` pulses of 4 cycles each, then `pll_fail`=1, `state`=4, `pll_rst`=1 held; `relock_req` → `pll_fail`=0 and a new `pll_rst` pulse.
- **Lock loss:** from READY, drop `pll_locked` → `pll_ready`=0 within 3 edges, `lock_lost_cnt`=1, re-lock sequence runs; repeat 260 times → `lock_lost_cnt`=255.
- **Priority:** `relock_req` coincident with `locked_s` falling in READY → RESET, `lock_lost_cnt` unchanged.
- **Async reset mid-STABLE:** assert `rst_n`=0 mid-STABLE → all outputs take their reset values immediately, without waiting for a `refclk` edge.
